oc_accumulator: RTL and testbench
=================================

// Module: oc_accumulator
// PURPOSE
//  Multi-cycle ones'-complement accumulator that sits directly downstream of the sign-magnitude
//  -> ones'-complement negator stage. It consumes a stream of ones'-complement words over a
//  valid/ready handshake and sums them with end-around carry. It reports the folded sum, the
//  word count and a sticky signed-overflow flag once the word marked last has been folded in.
// PARAMETERS
//  WIDTH          32  data width of operands and sum
//  CNT_W          16  width of word counter (saturating)
//  NORM_NEG_ZERO  1   1: result all-ones (-0) is reported as all-zeros (+0); 0: reported as is
// PORTS
//  clk        in   1        clock, all state changes on rising edge
//  reset      in   1        synchronous, active-high reset
//  start      in   1        begin a new accumulation (honoured only in IDLE)
//  in_valid   in   1        in_data/in_last valid
//  in_ready   out  1        block accepts a word this cycle
//  in_data    in   WIDTH    ones'-complement operand (negator output)
//  in_last    in   1        this word is the final word of the sequence
//  out_valid  out  1        result valid, held until out_ready
//  out_ready  in   1        consumer takes the result
//  out_sum    out  WIDTH    folded ones'-complement sum
//  out_count  out  CNT_W    number of words accumulated
//  out_ovf    out  1        sticky signed overflow seen during the sequence
//  busy       out  1        state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE; acc, raw, count, ovf cleared; in_ready=0, out_valid=0, busy=0; out_sum=0.
//    Reset in any state, including mid-sequence or while out_valid, aborts and discards the sequence.
//  - FSM IDLE -> RUN -> FOLD -> (RUN | DONE) -> IDLE.
//  - IDLE: in_ready=0. start=1 -> RUN; acc<=0, count<=0, ovf<=0. start outside IDLE is ignored.
//  - RUN: in_ready=1. On in_valid&&in_ready: raw<=acc+in_data as a WIDTH+1-bit sum; latch
//    in_data MSB and in_last; -> FOLD. With no valid word, the FSM stays in RUN indefinitely.
//  - FOLD: in_ready=0. acc<=raw[WIDTH-1:0]+raw[WIDTH]. A second carry cannot occur, so a
//    single fold is sufficient. count<=count+1, saturating at 2^CNT_W-1.
//    Overflow: ovf<=ovf | (old acc MSB == operand MSB && new acc MSB != old acc MSB).
//    If the latched last=1 -> DONE, else -> RUN.
//  - Throughput is one word per 2 cycles. Latency is 2 cycles from acceptance of the last word
//    to out_valid=1.
//  - DONE: out_valid=1; out_sum/out_count/out_ovf remain stable while out_ready=0. On out_ready=1
//    -> IDLE, and out_valid drops the next cycle. start asserted in DONE is ignored.
//  - out_sum = (NORM_NEG_ZERO && acc=={WIDTH{1'b1}}) ? 0 : acc. The same normalisation also
//    applies in states other than DONE.
//  - A zero-word sequence is not possible: at least one word, tagged last, is required to reach DONE.
// TESTING
//  1) start; words 0x00000005, 0xFFFFFFFC(last) -> out_sum=0x00000002, out_count=2, out_ovf=0.
//  2) NORM_NEG_ZERO=1; words 0x00000001, 0xFFFFFFFE(last) -> out_sum=0x00000000; with
//     NORM_NEG_ZERO=0 -> out_sum=0xFFFFFFFF.
//  3) words 0x7FFFFFFF, 0x00000001(last) -> out_sum=0x80000000, out_ovf=1. Then a fresh start;
//     0x00000003(last) -> out_ovf=0, out_count=1.
//  4) in_valid toggled randomly -> in_ready high only in RUN, no word lost or duplicated.
//     Hold out_ready=0 for 5 cycles in DONE -> outputs stable; then out_ready=1 -> IDLE.
//  5) reset asserted in FOLD after 3 words -> next cycle IDLE, busy=0, count=0. start pulsed
//     mid-RUN -> ignored, count is not cleared.
//  6) CNT_W=2; 5 words of 0x00000001 -> out_count=3 (saturated), out_sum=0x00000005.

Source files
------------

// File: rtl/oc_accumulator.sv
// Ones'-complement stream accumulator with end-around carry.
// Each accepted word takes two cycles: RUN captures the raw WIDTH+1-bit sum,
// FOLD adds the carry back in, bumps the word counter and updates the sticky
// overflow flag. The result is held in DONE until the consumer takes it.
module oc_accumulator #(
   parameter int WIDTH         = 32,
   parameter int CNT_W         = 16,
   parameter bit NORM_NEG_ZERO = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic [CNT_W-1:0] out_count,
   output logic             out_ovf,
   output logic             busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FOLD = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_next;

   logic [WIDTH-1:0] r_acc;
   logic [WIDTH:0]   r_raw;     // acc + operand with the carry-out kept in the top bit
   logic             r_op_msb;  // sign of the operand being folded in
   logic             r_last;
   logic [CNT_W-1:0] r_count;
   logic             r_ovf;

   logic [WIDTH-1:0] w_folded;
   logic             w_ovf_step;
   logic             w_count_sat;

   // End-around carry: raw is at most 2*(2^WIDTH-1), so adding the carry back
   // once can never produce a second carry.
   assign w_folded    = r_raw[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, r_raw[WIDTH]};
   // Signed overflow: both addends share a sign and the result flips it.
   assign w_ovf_step  = (r_acc[WIDTH-1] == r_op_msb) && (w_folded[WIDTH-1] != r_acc[WIDTH-1]);
   assign w_count_sat = &r_count;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state decode and handshake outputs.
   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      busy         = 1'b1;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) w_state_next = S_RUN;
         end
         S_RUN: begin
            in_ready = 1'b1;
            if (in_valid) w_state_next = S_FOLD;
         end
         S_FOLD: begin
            w_state_next = r_last ? S_DONE : S_RUN;
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Datapath: capture in RUN, fold/count/overflow in FOLD, clear on start.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc    <= '0;
         r_raw    <= '0;
         r_op_msb <= 1'b0;
         r_last   <= 1'b0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_acc   <= '0;
                  r_count <= '0;
                  r_ovf   <= 1'b0;
               end
            end
            S_RUN: begin
               if (in_valid) begin
                  r_raw    <= {1'b0, r_acc} + {1'b0, in_data};
                  r_op_msb <= in_data[WIDTH-1];
                  r_last   <= in_last;
               end
            end
            S_FOLD: begin
               r_acc <= w_folded;
               r_ovf <= r_ovf | w_ovf_step;
               if (!w_count_sat) r_count <= r_count + 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   // Result view; negative zero is optionally reported as positive zero.
   assign out_sum   = ((NORM_NEG_ZERO != 1'b0) && (&r_acc)) ? '0 : r_acc;
   assign out_count = r_count;
   assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_oc_accumulator.sv
// Scoreboard bench for oc_accumulator. Three instances run in lockstep on the
// same stimulus: default parameters, NORM_NEG_ZERO=0, and CNT_W=2. Expected
// results are queued when a sequence is issued; a monitor on the falling edge
// compares whatever the instances present while out_valid is high.
module tb_oc_accumulator;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_last;
   logic        out_ready;

   logic        in_ready_a, out_valid_a, out_ovf_a, busy_a;
   logic [31:0] out_sum_a;
   logic [15:0] out_count_a;
   logic        in_ready_b, out_valid_b, out_ovf_b, busy_b;
   logic [31:0] out_sum_b;
   logic [15:0] out_count_b;
   logic        in_ready_c, out_valid_c, out_ovf_c, busy_c;
   logic [31:0] out_sum_c;
   logic [1:0]  out_count_c;

   typedef struct {
      logic [31:0] sum;
      logic [31:0] sum_nz;
      logic [15:0] cnt;
      logic [1:0]  cnt_c2;
      logic        ovf;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   logic [31:0] words[$];
   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;

   oc_accumulator #(.WIDTH(32), .CNT_W(16), .NORM_NEG_ZERO(1'b1)) dut_a (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready_a),
      .in_data(in_data), .in_last(in_last), .out_valid(out_valid_a), .out_ready(out_ready),
      .out_sum(out_sum_a), .out_count(out_count_a), .out_ovf(out_ovf_a), .busy(busy_a));

   oc_accumulator #(.WIDTH(32), .CNT_W(16), .NORM_NEG_ZERO(1'b0)) dut_b (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready_b),
      .in_data(in_data), .in_last(in_last), .out_valid(out_valid_b), .out_ready(out_ready),
      .out_sum(out_sum_b), .out_count(out_count_b), .out_ovf(out_ovf_b), .busy(busy_b));

   oc_accumulator #(.WIDTH(32), .CNT_W(2), .NORM_NEG_ZERO(1'b1)) dut_c (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready_c),
      .in_data(in_data), .in_last(in_last), .out_valid(out_valid_c), .out_ready(out_ready),
      .out_sum(out_sum_c), .out_count(out_count_c), .out_ovf(out_ovf_c), .busy(busy_c));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
      end
   endtask

   task automatic push_exp(input logic [31:0] s, input logic [31:0] snz, input logic [15:0] c,
                           input logic [1:0] c2, input logic o);
      exp_t e;
      e.sum = s; e.sum_nz = snz; e.cnt = c; e.cnt_c2 = c2; e.ovf = o;
      sb_q.push_back(e);
   endtask

   // Monitor: compare the presented result every cycle it is valid, retire on handshake.
   always @(negedge clk) begin
      if (!reset && out_valid_a) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result: out_sum=0x%08h presented, no result expected", out_sum_a);
         end else begin
            mon_e = sb_q[0];
            chk("sum",        out_sum_a,           mon_e.sum);
            chk("count",      32'(out_count_a),    32'(mon_e.cnt));
            chk("ovf",        32'(out_ovf_a),      32'(mon_e.ovf));
            chk("sum_nz",     out_sum_b,           mon_e.sum_nz);
            chk("valid_nz",   32'(out_valid_b),    32'd1);
            chk("count_c2",   32'(out_count_c),    32'(mon_e.cnt_c2));
            chk("sum_c2",     out_sum_c,           mon_e.sum);
            chk("valid_c2",   32'(out_valid_c),    32'd1);
            if (out_ready) void'(sb_q.pop_front());
         end
      end
   end

   task automatic do_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("start_busy",     32'(busy_a),     32'd1);
      chk("start_in_ready", 32'(in_ready_a), 32'd1);
   endtask

   // Present one word after 'idle' empty cycles; optionally keep in_valid high
   // through the FOLD cycle so a word accepted outside RUN would be duplicated.
   task automatic send_word(input logic [31:0] d, input logic l, input int idle, input bit hv);
      int n;
      if (idle > 0) begin
         in_valid = 1'b0;
         repeat (idle) begin @(posedge clk); #1; end
      end
      in_data  = d;
      in_last  = l;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready_a && n < 50) begin @(posedge clk); #1; n++; end
      if (!in_ready_a) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: in_ready=0 after %0d cycles, expected 1", n);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      chk("in_ready_fold", 32'(in_ready_a), 32'd0);
      if (hv && !l) begin @(posedge clk); #1; end
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input int hold, input bit start_in_done);
      int n;
      n = 0;
      while (!out_valid_a && n < 20) begin @(posedge clk); #1; n++; end
      if (!out_valid_a) begin
         n_checks++;
         n_fail++;
         $display("FAIL done_timeout: out_valid=0 after %0d cycles, expected 1", n);
         if (sb_q.size() > 0) void'(sb_q.pop_front());
         return;
      end
      chk("done_latency", 32'(n), 32'd1);
      for (int k = 0; k < hold; k++) begin
         if (start_in_done && k == 1) start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("valid_drop", 32'(out_valid_a), 32'd0);
      chk("idle_busy",  32'(busy_a),      32'd0);
   endtask

   task automatic run_seq(input int idle_max, input int hold, input bit hv_en, input bit sd);
      do_start();
      for (int i = 0; i < words.size(); i++) begin
         send_word(words[i], (i == words.size() - 1), int'($urandom_range(0, idle_max)),
                   hv_en && ($urandom_range(0, 1) == 1));
      end
      wait_done(hold, sd);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_in_ready",  32'(in_ready_a),  32'd0);
      chk("rst_out_valid", 32'(out_valid_a), 32'd0);
      chk("rst_busy",      32'(busy_a),      32'd0);
      chk("rst_sum",       out_sum_a,        32'd0);
      chk("rst_count",     32'(out_count_a), 32'd0);
      chk("rst_ovf",       32'(out_ovf_a),   32'd0);
      chk("rst_count_c2",  32'(out_count_c), 32'd0);

      // Basic sum with end-around carry.
      words = {32'h0000_0005, 32'hFFFF_FFFC};
      push_exp(32'h0000_0002, 32'h0000_0002, 16'd2, 2'd2, 1'b0);
      run_seq(0, 0, 1'b0, 1'b0);

      // Result -0: normalised vs raw.
      words = {32'h0000_0001, 32'hFFFF_FFFE};
      push_exp(32'h0000_0000, 32'hFFFF_FFFF, 16'd2, 2'd2, 1'b0);
      run_seq(0, 0, 1'b0, 1'b0);

      // -0 + -0 folds back to -0.
      words = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
      push_exp(32'h0000_0000, 32'hFFFF_FFFF, 16'd2, 2'd2, 1'b0);
      run_seq(1, 1, 1'b0, 1'b0);

      // Positive overflow, then a fresh start clears the flag.
      words = {32'h7FFF_FFFF, 32'h0000_0001};
      push_exp(32'h8000_0000, 32'h8000_0000, 16'd2, 2'd2, 1'b1);
      run_seq(0, 0, 1'b0, 1'b0);
      words = {32'h0000_0003};
      push_exp(32'h0000_0003, 32'h0000_0003, 16'd1, 2'd1, 1'b0);
      run_seq(0, 0, 1'b0, 1'b0);

      // Negative overflow.
      words = {32'h8000_0000, 32'hFFFF_FFFE};
      push_exp(32'h7FFF_FFFF, 32'h7FFF_FFFF, 16'd2, 2'd2, 1'b1);
      run_seq(0, 0, 1'b0, 1'b0);

      // Overflow flag stays set after a later non-overflowing word.
      words = {32'h7FFF_FFFF, 32'h0000_0001, 32'h0000_0001};
      push_exp(32'h8000_0001, 32'h8000_0001, 16'd3, 2'd3, 1'b1);
      run_seq(0, 0, 1'b0, 1'b0);

      // Random valid gaps, valid held across FOLD, result held 5 cycles, start in DONE.
      words = {32'h0000_0010, 32'h0000_0020, 32'hFFFF_FFFE, 32'h0000_0100};
      push_exp(32'h0000_012F, 32'h0000_012F, 16'd4, 2'd3, 1'b0);
      run_seq(3, 5, 1'b1, 1'b1);

      // Reset while in FOLD after the third word aborts the sequence.
      do_start();
      send_word(32'h0000_0001, 1'b0, 0, 1'b0);
      send_word(32'h0000_0002, 1'b0, 0, 1'b0);
      send_word(32'h0000_0003, 1'b0, 0, 1'b0);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("abort_busy",      32'(busy_a),      32'd0);
      chk("abort_count",     32'(out_count_a), 32'd0);
      chk("abort_sum",       out_sum_a,        32'd0);
      chk("abort_in_ready",  32'(in_ready_a),  32'd0);
      chk("abort_out_valid", 32'(out_valid_a), 32'd0);
      chk("abort_count_c2",  32'(out_count_c), 32'd0);

      // start pulsed while in RUN must not clear the running count.
      push_exp(32'h0000_0003, 32'h0000_0003, 16'd2, 2'd2, 1'b0);
      do_start();
      send_word(32'h0000_0001, 1'b0, 0, 1'b0);
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("midrun_count", 32'(out_count_a), 32'd1);
      chk("midrun_busy",  32'(busy_a),      32'd1);
      send_word(32'h0000_0002, 1'b1, 0, 1'b0);
      wait_done(0, 1'b0);

      // Counter saturation on the CNT_W=2 instance.
      words.delete();
      for (int i = 0; i < 5; i++) words.push_back(32'h0000_0001);
      push_exp(32'h0000_0005, 32'h0000_0005, 16'd5, 2'd3, 1'b0);
      run_seq(1, 2, 1'b0, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
